// File: rtl/execute_pkg.sv
// Shared types and constants for the ppcpu execute stage.
// ALU op codes and jump conditions are also consumed by decode.
package execute_pkg;

    localparam int RW    = 16;
    localparam int REGNO = 8;

    localparam logic [3:0] EX_OP_MOV = 4'd0;
    localparam logic [3:0] EX_OP_ADD = 4'd1;
    localparam logic [3:0] EX_OP_ADC = 4'd2;
    localparam logic [3:0] EX_OP_SUB = 4'd3;
    localparam logic [3:0] EX_OP_SBC = 4'd4;
    localparam logic [3:0] EX_OP_AND = 4'd5;
    localparam logic [3:0] EX_OP_OR  = 4'd6;
    localparam logic [3:0] EX_OP_XOR = 4'd7;
    localparam logic [3:0] EX_OP_SHL = 4'd8;
    localparam logic [3:0] EX_OP_SHR = 4'd9;
    localparam logic [3:0] EX_OP_SAR = 4'd10;
    localparam logic [3:0] EX_OP_MUL = 4'd11;
    localparam logic [3:0] EX_OP_CMP = 4'd12;

    localparam logic [2:0] EX_JC_NEVER = 3'd0;
    localparam logic [2:0] EX_JC_ALWAYS = 3'd1;
    localparam logic [2:0] EX_JC_Z     = 3'd2;
    localparam logic [2:0] EX_JC_NZ    = 3'd3;
    localparam logic [2:0] EX_JC_C     = 3'd4;
    localparam logic [2:0] EX_JC_NC    = 3'd5;
    localparam logic [2:0] EX_JC_N     = 3'd6;
    localparam logic [2:0] EX_JC_O     = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_PEND,
        ST_BUSY
    } ex_state_e;

    typedef struct packed {
        logic o;
        logic n;
        logic c;
        logic z;
    } ex_flags_t;

    typedef struct packed {
        logic [REGNO-1:0] reg_ie;
        logic             flags_we;
        logic [2:0]       jmp_cond;
        logic [RW-1:0]    imm;
    } ex_ctx_t;

    function automatic logic jmp_taken(input logic [2:0] cond,
                                       input ex_flags_t f);
        logic t;
        case (cond)
            EX_JC_NEVER:  t = 1'b0;
            EX_JC_ALWAYS: t = 1'b1;
            EX_JC_Z:      t = f.z;
            EX_JC_NZ:     t = ~f.z;
            EX_JC_C:      t = f.c;
            EX_JC_NC:     t = ~f.c;
            EX_JC_N:      t = f.n;
            default:      t = f.o;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/execute_alu.sv
// Combinational ALU: result plus {O,N,C,Z} for every op except MUL,
// which is sequenced by the stage and passed through here as MOV.
module execute_alu
    import execute_pkg::*;
(
    input  logic [3:0]    op_i,
    input  logic [RW-1:0] a_i,
    input  logic [RW-1:0] b_i,
    input  logic          c_i,
    output logic [RW-1:0] res_o,
    output ex_flags_t     flags_o
);

    logic [RW:0]   add_w;
    logic [RW:0]   sub_w;
    logic [RW:0]   shl_w;
    logic [RW:0]   shr_w;
    logic [RW:0]   sar_w;
    logic [3:0]    amt;
    logic          cin_add;
    logic          cin_sub;
    logic          add_ovf;
    logic          sub_ovf;
    logic [RW-1:0] res;
    logic          c;
    logic          o;

    assign amt     = b_i[3:0];
    assign cin_add = (op_i == EX_OP_ADC) & c_i;
    assign cin_sub = (op_i == EX_OP_SBC) & c_i;
    assign add_w   = {1'b0, a_i} + {1'b0, b_i} + {{RW{1'b0}}, cin_add};
    // Bit RW of the difference is the borrow.
    assign sub_w   = {1'b0, a_i} - {1'b0, b_i} - {{RW{1'b0}}, cin_sub};
    assign shl_w   = {1'b0, a_i} << amt;
    assign shr_w   = {a_i, 1'b0} >> amt;
    assign sar_w   = $signed({a_i, 1'b0}) >>> amt;
    assign add_ovf = (a_i[RW-1] == b_i[RW-1]) & (add_w[RW-1] != a_i[RW-1]);
    assign sub_ovf = (a_i[RW-1] != b_i[RW-1]) & (sub_w[RW-1] != a_i[RW-1]);

    always_comb begin
        res = b_i;
        c   = 1'b0;
        o   = 1'b0;
        case (op_i)
            EX_OP_ADD, EX_OP_ADC: begin
                res = add_w[RW-1:0];
                c   = add_w[RW];
                o   = add_ovf;
            end
            EX_OP_SUB, EX_OP_SBC, EX_OP_CMP: begin
                res = sub_w[RW-1:0];
                c   = sub_w[RW];
                o   = sub_ovf;
            end
            EX_OP_AND: res = a_i & b_i;
            EX_OP_OR:  res = a_i | b_i;
            EX_OP_XOR: res = a_i ^ b_i;
            EX_OP_SHL: begin
                res = shl_w[RW-1:0];
                c   = shl_w[RW];
            end
            EX_OP_SHR: begin
                res = shr_w[RW:1];
                c   = shr_w[0];
            end
            EX_OP_SAR: begin
                res = sar_w[RW:1];
                c   = sar_w[0];
            end
            default: res = b_i;
        endcase
    end

    assign res_o     = res;
    assign flags_o.o = o;
    assign flags_o.n = res[RW-1];
    assign flags_o.c = c;
    assign flags_o.z = (res == '0);

endmodule

// File: rtl/execute.sv
// ppcpu execute stage: ALU, iterative MUL, flags, jumps and the
// registered bundle handed to memory/writeback.
module execute
    import execute_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_submit,
    output logic             o_ready,
    input  logic [3:0]       i_alu_op,
    input  logic [RW-1:0]    i_a,
    input  logic [RW-1:0]    i_b,
    input  logic [RW-1:0]    i_imm,
    input  logic             i_use_imm,
    input  logic [REGNO-1:0] i_reg_ie,
    input  logic             i_mem_access,
    input  logic             i_mem_we,
    input  logic             i_mem_width,
    input  logic             i_flags_we,
    input  logic [2:0]       i_jmp_cond,
    output logic [RW-1:0]    o_data,
    output logic [RW-1:0]    o_addr,
    output logic [REGNO-1:0] o_reg_ie,
    output logic             o_mem_access,
    output logic             o_mem_we,
    output logic             o_mem_width,
    output logic             o_submit,
    input  logic             i_next_ready,
    output logic             o_jmp,
    output logic [RW-1:0]    o_jmp_addr,
    output logic [3:0]       o_flags
);

    ex_state_e        state_q;
    logic [3:0]       cnt_q;
    logic [RW-1:0]    mcand_q;
    logic [RW-1:0]    mplier_q;
    logic [RW-1:0]    acc_q;
    ex_ctx_t          ctx_q;
    ex_ctx_t          ctx_in;
    ex_ctx_t          lat_ctx;
    ex_flags_t        flags_q;
    ex_flags_t        alu_flags;
    logic [RW-1:0]    data_q;
    logic [RW-1:0]    addr_q;
    logic [RW-1:0]    jaddr_q;
    logic [REGNO-1:0] reg_ie_q;
    logic             mem_acc_q;
    logic             mem_we_q;
    logic             mem_w_q;
    logic             submit_q;
    logic             jmp_q;

    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             mul_last;
    logic             latch;
    logic             lat_mem;
    logic [RW-1:0]    op_b;
    logic [RW-1:0]    mul_add;
    logic [RW-1:0]    mul_prod;
    logic [RW-1:0]    alu_b;
    logic [RW-1:0]    alu_res;
    logic [3:0]       alu_op;

    assign o_ready   = (state_q == ST_IDLE) |
                       ((state_q == ST_BUSY) & ~submit_q & i_next_ready);
    assign accept    = i_submit & o_ready;
    assign is_mul    = (i_alu_op == EX_OP_MUL) & ~i_mem_access;
    assign mul_start = accept & is_mul;
    assign mul_last  = (state_q == ST_MUL) & (cnt_q == 4'd15);
    assign latch     = (accept & ~is_mul) | mul_last;
    assign lat_mem   = ~mul_last & i_mem_access;

    assign op_b     = i_use_imm ? i_imm : i_b;
    assign mul_add  = mplier_q[0] ? mcand_q : '0;
    assign mul_prod = acc_q + mul_add;

    // The finished product goes through the ALU as MOV to get Z/N.
    assign alu_op  = mul_last ? EX_OP_MOV : i_alu_op;
    assign alu_b   = mul_last ? mul_prod : op_b;
    assign ctx_in  = {i_reg_ie, i_flags_we, i_jmp_cond, i_imm};
    assign lat_ctx = mul_last ? ctx_q : ctx_in;

    execute_alu u_alu (
        .op_i    (alu_op),
        .a_i     (i_a),
        .b_i     (alu_b),
        .c_i     (flags_q.c),
        .res_o   (alu_res),
        .flags_o (alu_flags)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            ctx_q    <= '0;
            submit_q <= 1'b0;
        end else begin
            submit_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept)
                        state_q <= is_mul ? ST_MUL : ST_PEND;
                end
                ST_MUL: begin
                    cnt_q    <= cnt_q + 4'd1;
                    acc_q    <= mul_prod;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    if (mul_last)
                        state_q <= ST_PEND;
                end
                ST_PEND: begin
                    if (i_next_ready && !submit_q) begin
                        state_q  <= ST_BUSY;
                        submit_q <= 1'b1;
                    end
                end
                default: begin
                    if (accept)
                        state_q <= is_mul ? ST_MUL : ST_PEND;
                    else if (!submit_q && i_next_ready)
                        state_q <= ST_IDLE;
                end
            endcase
            if (mul_start) begin
                mcand_q  <= i_a;
                mplier_q <= op_b;
                acc_q    <= '0;
                cnt_q    <= '0;
                ctx_q    <= ctx_in;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q    <= '0;
            addr_q    <= '0;
            reg_ie_q  <= '0;
            mem_acc_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_w_q   <= 1'b0;
            jaddr_q   <= '0;
            jmp_q     <= 1'b0;
            flags_q   <= '0;
        end else begin
            jmp_q <= 1'b0;
            if (latch) begin
                data_q    <= lat_mem ? i_b : alu_res;
                addr_q    <= lat_mem ? i_a + i_imm : alu_res;
                reg_ie_q  <= (~lat_mem & (alu_op == EX_OP_CMP)) ?
                             '0 : lat_ctx.reg_ie;
                mem_acc_q <= lat_mem;
                mem_we_q  <= lat_mem & i_mem_we;
                mem_w_q   <= lat_mem & i_mem_width;
                jaddr_q   <= lat_ctx.imm;
                jmp_q     <= jmp_taken(lat_ctx.jmp_cond, flags_q);
                if (lat_ctx.flags_we && !lat_mem)
                    flags_q <= alu_flags;
            end
        end
    end

    assign o_data       = data_q;
    assign o_addr       = addr_q;
    assign o_reg_ie     = reg_ie_q;
    assign o_mem_access = mem_acc_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_width  = mem_w_q;
    assign o_submit     = submit_q;
    assign o_jmp        = jmp_q;
    assign o_jmp_addr   = jaddr_q;
    assign o_flags      = flags_q;

endmodule
